// File: rtl/lcd_write_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_write_scheduler: arbitrates the LCD write port between CPU writes and  |
// | a hex status renderer (PC/ACC), CPU first with a renderer starvation guard.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lcd_write_scheduler #(
  parameter int REFRESH_DIV  = 50000,
  parameter int STATUS_BASE  = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        cpuWrite,
  input  logic [4:0]  cpuLocation,
  input  logic [7:0]  cpuData,
  output logic        cpuReady,
  input  logic        statusEnable,
  input  logic [15:0] statusPc,
  input  logic [7:0]  statusAcc,
  output logic        lcdWriteEnable,
  output logic [4:0]  lcdLocation,
  output logic [7:0]  lcdData
);

  localparam int REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int STARVE_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [REFRESH_W-1:0] REFRESH_RELOAD = REFRESH_W'(REFRESH_DIV - 1);
  localparam logic [STARVE_W-1:0]  STARVE_MAX     = STARVE_W'(STARVE_LIMIT);
  localparam logic [4:0]           BASE_LOC       = 5'(STATUS_BASE);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_SNAP = 2'd1,
    R_EMIT = 2'd2
  } rstate_t;

  rstate_t               rstate_q, rstate_d;
  logic [REFRESH_W-1:0]  refresh_q, refresh_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic [2:0]            idx_q, idx_d;
  logic [15:0]           last_pc_q, last_pc_d;
  logic [7:0]            last_acc_q, last_acc_d;
  logic                  last_valid_q, last_valid_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [4:0]            hold_loc_q, hold_loc_d;
  logic [7:0]            hold_data_q, hold_data_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic                  lcd_we_q, lcd_we_d;
  logic [4:0]            lcd_loc_q, lcd_loc_d;
  logic [7:0]            lcd_data_q, lcd_data_d;

  logic [3:0]            digit_nib;
  logic [7:0]            digit_char;
  logic [4:0]            digit_loc;
  logic                  digit_pending;
  logic                  digit_issue;
  logic                  cpu_accept;

  // The snapshot lives in last_pc_q/last_acc_q, so the field text is stable for the whole sequence.
  always_comb begin
    case (idx_q)
      3'd0:    digit_nib = last_pc_q[15:12];
      3'd1:    digit_nib = last_pc_q[11:8];
      3'd2:    digit_nib = last_pc_q[7:4];
      3'd3:    digit_nib = last_pc_q[3:0];
      3'd5:    digit_nib = last_acc_q[7:4];
      3'd6:    digit_nib = last_acc_q[3:0];
      default: digit_nib = 4'h0;
    endcase
    if (idx_q == 3'd4)            digit_char = 8'h20;
    else if (digit_nib < 4'd10)   digit_char = {4'h3, digit_nib};
    else                          digit_char = 8'h37 + {4'h0, digit_nib};
    digit_loc = BASE_LOC + {2'b00, idx_q};
  end

  always_comb begin
    rstate_d     = rstate_q;
    refresh_d    = refresh_q;
    starve_d     = starve_q;
    idx_d        = idx_q;
    last_pc_d    = last_pc_q;
    last_acc_d   = last_acc_q;
    last_valid_d = last_valid_q;
    hold_valid_d = hold_valid_q;
    hold_loc_d   = hold_loc_q;
    hold_data_d  = hold_data_q;
    cpu_ready_d  = cpu_ready_q;
    lcd_we_d     = 1'b0;
    lcd_loc_d    = lcd_loc_q;
    lcd_data_d   = lcd_data_q;
    digit_issue  = 1'b0;
    digit_pending = (rstate_q == R_EMIT);
    cpu_accept    = cpuWrite & cpu_ready_q;

    if (hold_valid_q) begin
      lcd_we_d     = 1'b1;
      lcd_loc_d    = hold_loc_q;
      lcd_data_d   = hold_data_q;
      hold_valid_d = 1'b0;
      cpu_ready_d  = 1'b1;
    end else if (digit_pending && (starve_q == STARVE_MAX)) begin
      // Renderer takes the slot; a simultaneous CPU write is parked for one cycle.
      digit_issue = 1'b1;
      starve_d    = '0;
      if (cpu_accept) begin
        hold_valid_d = 1'b1;
        hold_loc_d   = cpuLocation;
        hold_data_d  = cpuData;
        cpu_ready_d  = 1'b0;
      end
    end else if (cpu_accept) begin
      lcd_we_d   = 1'b1;
      lcd_loc_d  = cpuLocation;
      lcd_data_d = cpuData;
      if (digit_pending) starve_d = starve_q + STARVE_W'(1);
    end else if (digit_pending) begin
      digit_issue = 1'b1;
      starve_d    = '0;
    end

    if (digit_issue) begin
      lcd_we_d   = 1'b1;
      lcd_loc_d  = digit_loc;
      lcd_data_d = digit_char;
    end

    case (rstate_q)
      R_IDLE: begin
        if (!statusEnable) begin
          refresh_d = REFRESH_RELOAD;
        end else if (refresh_q == '0) begin
          rstate_d  = R_SNAP;
          refresh_d = REFRESH_RELOAD;
        end else begin
          refresh_d = refresh_q - REFRESH_W'(1);
        end
      end
      R_SNAP: begin
        if (last_valid_q && (statusPc == last_pc_q) && (statusAcc == last_acc_q)) begin
          rstate_d = R_IDLE;
        end else begin
          last_pc_d    = statusPc;
          last_acc_d   = statusAcc;
          last_valid_d = 1'b1;
          idx_d        = 3'd0;
          rstate_d     = R_EMIT;
        end
      end
      R_EMIT: begin
        if (digit_issue) begin
          if (idx_q == 3'd6) rstate_d = R_IDLE;
          else               idx_d    = idx_q + 3'd1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      rstate_q     <= R_IDLE;
      refresh_q    <= REFRESH_RELOAD;
      starve_q     <= '0;
      idx_q        <= 3'd0;
      last_pc_q    <= 16'h0000;
      last_acc_q   <= 8'h00;
      last_valid_q <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_loc_q   <= 5'd0;
      hold_data_q  <= 8'h00;
      cpu_ready_q  <= 1'b1;
      lcd_we_q     <= 1'b0;
      lcd_loc_q    <= 5'd0;
      lcd_data_q   <= 8'h00;
    end else begin
      rstate_q     <= rstate_d;
      refresh_q    <= refresh_d;
      starve_q     <= starve_d;
      idx_q        <= idx_d;
      last_pc_q    <= last_pc_d;
      last_acc_q   <= last_acc_d;
      last_valid_q <= last_valid_d;
      hold_valid_q <= hold_valid_d;
      hold_loc_q   <= hold_loc_d;
      hold_data_q  <= hold_data_d;
      cpu_ready_q  <= cpu_ready_d;
      lcd_we_q     <= lcd_we_d;
      lcd_loc_q    <= lcd_loc_d;
      lcd_data_q   <= lcd_data_d;
    end
  end

  assign cpuReady       = cpu_ready_q;
  assign lcdWriteEnable = lcd_we_q;
  assign lcdLocation    = lcd_loc_q;
  assign lcdData        = lcd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_scheduler.sv
`default_nettype none
// Bench for lcd_write_scheduler: two instances (field at 16 and at 29) share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_lcd_write_scheduler;

  localparam int DIV   = 4;
  localparam int LIMIT = 8;
  localparam int BASE_A = 16;
  localparam int BASE_B = 29;

  logic        clk = 1'b0;
  logic        rst_n, cpu_write, status_en;
  logic [4:0]  cpu_loc;
  logic [7:0]  cpu_data, status_acc;
  logic [15:0] status_pc;

  logic        a_we, a_ready, b_we, b_ready;
  logic [4:0]  a_loc, b_loc;
  logic [7:0]  a_data, b_data;

  always #5 clk = ~clk;

  lcd_write_scheduler #(.REFRESH_DIV(DIV), .STATUS_BASE(BASE_A), .STARVE_LIMIT(LIMIT)) dut_a (
    .clk(clk), .resetN(rst_n), .cpuWrite(cpu_write), .cpuLocation(cpu_loc), .cpuData(cpu_data),
    .cpuReady(a_ready), .statusEnable(status_en), .statusPc(status_pc), .statusAcc(status_acc),
    .lcdWriteEnable(a_we), .lcdLocation(a_loc), .lcdData(a_data));

  lcd_write_scheduler #(.REFRESH_DIV(DIV), .STATUS_BASE(BASE_B), .STARVE_LIMIT(LIMIT)) dut_b (
    .clk(clk), .resetN(rst_n), .cpuWrite(cpu_write), .cpuLocation(cpu_loc), .cpuData(cpu_data),
    .cpuReady(b_ready), .statusEnable(status_en), .statusPc(status_pc), .statusAcc(status_acc),
    .lcdWriteEnable(b_we), .lcdLocation(b_loc), .lcdData(b_data));

  int total = 0;
  int bad   = 0;

  // Reference model: pending field text is a queue of characters built at snapshot time.
  bit          m_we, m_isdig, m_ready, m_hold_v, m_in_snap, m_valid, m_after_reset;
  int          m_off, m_starve, m_countdown;
  logic [4:0]  m_cpu_loc, m_hold_loc;
  logic [7:0]  m_data, m_hold_data, m_acc;
  logic [15:0] m_pc;
  logic [7:0]  m_text[$];

  int          strobes, field_strobes, ready_low;
  logic [4:0]  log_loc_a[$], log_loc_b[$];
  logic [7:0]  log_data[$];

  function automatic logic [7:0] hex_char(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  function automatic logic [7:0] field_char(input logic [15:0] pc, input logic [7:0] acc, input int k);
    if (k == 4) return 8'h20;
    if (k < 4)  return hex_char(int'((pc >> (4 * (3 - k))) & 16'hF));
    return hex_char(int'((acc >> (4 * (6 - k))) & 8'hF));
  endfunction

  function automatic logic [4:0] exp_loc(input int base);
    if (m_isdig) return 5'((base + m_off) % 32);
    return m_cpu_loc;
  endfunction

  task automatic model_reset();
    m_we = 0; m_isdig = 0; m_cpu_loc = 5'd0; m_data = 8'h00; m_ready = 1;
    m_hold_v = 0; m_hold_loc = 5'd0; m_hold_data = 8'h00; m_starve = 0;
    m_in_snap = 0; m_countdown = DIV - 1; m_valid = 0; m_pc = 16'h0; m_acc = 8'h0;
    m_text = {}; m_off = 0;
  endtask

  task automatic model_step();
    bit pend, idle, acc, dig;
    if (!rst_n) begin
      model_reset();
      m_after_reset = 1;
      return;
    end
    m_after_reset = 0;
    pend = !m_in_snap && (m_text.size() > 0);
    idle = !m_in_snap && (m_text.size() == 0);
    acc  = cpu_write && m_ready;
    dig  = 0;
    m_we = 0;
    if (m_hold_v) begin
      m_we = 1; m_isdig = 0; m_cpu_loc = m_hold_loc; m_data = m_hold_data;
      m_hold_v = 0; m_ready = 1;
    end else if (pend && m_starve == LIMIT) begin
      dig = 1; m_starve = 0;
      if (acc) begin
        m_hold_v = 1; m_hold_loc = cpu_loc; m_hold_data = cpu_data; m_ready = 0;
      end
    end else if (acc) begin
      m_we = 1; m_isdig = 0; m_cpu_loc = cpu_loc; m_data = cpu_data;
      if (pend) m_starve++;
    end else if (pend) begin
      dig = 1; m_starve = 0;
    end
    if (dig) begin
      m_we = 1; m_isdig = 1; m_off = 7 - m_text.size(); m_data = m_text.pop_front();
    end
    if (m_in_snap) begin
      m_in_snap = 0;
      if (!(m_valid && status_pc == m_pc && status_acc == m_acc)) begin
        m_pc = status_pc; m_acc = status_acc; m_valid = 1;
        for (int k = 0; k < 7; k++) m_text.push_back(field_char(m_pc, m_acc, k));
      end
    end else if (idle) begin
      if (!status_en)            m_countdown = DIV - 1;
      else if (m_countdown == 0) begin m_in_snap = 1; m_countdown = DIV - 1; end
      else                       m_countdown--;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("we_a", 16'(a_we), 16'(m_we));
    check("we_b", 16'(b_we), 16'(m_we));
    check("ready_a", 16'(a_ready), 16'(m_ready));
    check("ready_b", 16'(b_ready), 16'(m_ready));
    if (m_we || m_after_reset) begin
      check("loc_a", 16'(a_loc), 16'(exp_loc(BASE_A)));
      check("loc_b", 16'(b_loc), 16'(exp_loc(BASE_B)));
      check("data_a", 16'(a_data), 16'(m_data));
      check("data_b", 16'(b_data), 16'(m_data));
    end
    if (a_we === 1'b1) begin
      strobes++;
      if (a_loc >= 5'd16) field_strobes++;
      log_loc_a.push_back(a_loc);
      log_loc_b.push_back(b_loc);
      log_data.push_back(a_data);
    end
    if (a_ready === 1'b0) ready_low++;
  endtask

  task automatic clear_tally();
    strobes = 0; field_strobes = 0; ready_low = 0;
    log_loc_a = {}; log_loc_b = {}; log_data = {};
  endtask

  task automatic wait_strobes(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && strobes < n; i++) cycle();
    check(tag, 16'(strobes), 16'(n));
  endtask

  logic [7:0] exp_text [7];
  bit         accepted;

  initial begin
    exp_text = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h20, 8'h33, 8'h43};
    model_reset();
    m_after_reset = 0;
    rst_n = 0; cpu_write = 0; cpu_loc = 5'd0; cpu_data = 8'h00;
    status_en = 1; status_pc = 16'h1A2F; status_acc = 8'h3C;
    clear_tally();

    // Reset, then first render of 1A2F / 3C
    cycle(); cycle();
    rst_n = 1;
    clear_tally();
    for (int i = 0; i < 30; i++) cycle();
    check("render_count", 16'(strobes), 16'd7);
    for (int i = 0; i < 7 && i < log_data.size(); i++) begin
      check("render_loc_a", 16'(log_loc_a[i]), 16'(16 + i));
      check("render_loc_b", 16'(log_loc_b[i]), 16'((29 + i) % 32));
      check("render_data", 16'(log_data[i]), 16'(exp_text[i]));
    end
    clear_tally();
    for (int i = 0; i < 20; i++) cycle();
    check("unchanged_silence", 16'(strobes), 16'd0);

    // Single CPU write with renderer idle
    clear_tally();
    cpu_write = 1; cpu_loc = 5'd5; cpu_data = 8'h48;
    cycle();
    cpu_write = 0;
    check("cpu_single_we", 16'(a_we), 16'd1);
    check("cpu_single_loc", 16'(a_loc), 16'd5);
    check("cpu_single_data", 16'(a_data), 16'h48);
    for (int i = 0; i < 3; i++) cycle();
    check("cpu_single_ready_low", 16'(ready_low), 16'd0);

    // Continuous CPU pressure during a render: starvation guard
    clear_tally();
    status_pc = 16'hBEEF;
    cpu_write = 1; cpu_loc = 5'($urandom_range(0, 15)); cpu_data = 8'($urandom);
    for (int i = 0; i < 90; i++) begin
      accepted = a_ready;
      cycle();
      if (accepted) begin
        cpu_loc = 5'($urandom_range(0, 15)); cpu_data = 8'($urandom);
      end
    end
    cpu_write = 0;
    check("starve_ready_low", 16'(ready_low), 16'd7);
    check("starve_digits", 16'(field_strobes), 16'd7);
    for (int i = 0; i < 5; i++) cycle();

    // Reset after three digits aborts; next scan re-renders everything
    clear_tally();
    status_acc = 8'h55;
    wait_strobes("mid_emit_three", 3, 30);
    rst_n = 0;
    cycle();
    check("mid_reset_we", 16'(a_we), 16'd0);
    check("mid_reset_ready", 16'(a_ready), 16'd1);
    rst_n = 1;
    clear_tally();
    for (int i = 0; i < 5; i++) cycle();
    check("post_reset_quiet", 16'(strobes), 16'd0);
    wait_strobes("post_reset_rerender", 7, 40);

    // Disable after the third digit: sequence still completes, no later scans
    for (int i = 0; i < 8; i++) cycle();
    clear_tally();
    status_pc = 16'h0042;
    wait_strobes("disable_first_three", 3, 30);
    status_en = 0;
    for (int i = 0; i < 20; i++) cycle();
    check("disable_completes", 16'(strobes), 16'd7);
    clear_tally();
    status_acc = 8'hFF;
    for (int i = 0; i < 30; i++) cycle();
    check("disabled_silence", 16'(strobes), 16'd0);

    // Random traffic
    status_en = 1;
    for (int i = 0; i < 2000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      status_en = ($urandom_range(0, 7) != 0);
      cpu_write = ($urandom_range(0, 2) == 0);
      cpu_loc   = 5'($urandom);
      cpu_data  = 8'($urandom);
      if ($urandom_range(0, 39) == 0) status_pc  = 16'($urandom);
      if ($urandom_range(0, 39) == 0) status_acc = 8'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_write_scheduler.md
Name: lcd_write_scheduler

Overview:
- Sequences the LCD character controller's single write port (writeEnable/location/data) between two requesters.
- Requester 1: the CPU character-write path.
- Requester 2: an internal status renderer that periodically formats a 16-bit PC and an 8-bit accumulator as hex into a fixed field, writing only when the values change.
- CPU has priority; a starvation guard guarantees renderer progress.

Parameters:
- REFRESH_DIV, 50000: cycles between status scans.
- STATUS_BASE, 16: first character location of the status field (5-bit).
- STARVE_LIMIT, 8: consecutive renderer stalls before the renderer takes a slot.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetN  in  1  reset, synchronous, active-low.
- cpuWrite  in  1  CPU character write request, valid when cpuReady=1.
- cpuLocation  in  5  CPU target location, 0-31.
- cpuData  in  8  CPU character code.
- cpuReady  out  1  CPU request accepted this cycle if cpuWrite=1.
- statusEnable  in  1  enables periodic status rendering.
- statusPc  in  16  value shown at STATUS_BASE+0..3.
- statusAcc  in  8  value shown at STATUS_BASE+5..6.
- lcdWriteEnable  out  1  one-cycle write strobe to the LCD controller.
- lcdLocation  out  5  write location.
- lcdData  out  8  write character.

Behaviour:
- Reset (resetN=0 at an edge): lcdWriteEnable=0, lcdLocation=0, lcdData=0, cpuReady=1. Hold register empty, starve counter 0, renderer IDLE, refresh counter=REFRESH_DIV-1, last-shown values invalid. Any reset mid-sequence aborts the sequence and drops the hold register.
- All outputs are registered.
- A write accepted at edge t drives lcdWriteEnable=1 with location/data for exactly cycle t..t+1. lcdWriteEnable is 0 on every cycle with no issue.
- Issue priority per edge, first match wins:
  1. Hold register full: issue it, empty it, cpuReady<=1.
  2. Renderer digit pending and starve==STARVE_LIMIT: issue the digit, starve<=0. If cpuWrite=1, latch it into the hold register and set cpuReady<=0, so cpuReady is low for exactly one cycle.
  3. cpuWrite=1: issue the CPU write directly. If a renderer digit is pending, starve<=starve+1.
  4. Renderer digit pending: issue it, starve<=0.
- cpuWrite while cpuReady=0 is ignored; the CPU must hold it.
- Renderer FSM:
  - IDLE: if statusEnable, decrement the refresh counter; at 0 go to SNAP and reload REFRESH_DIV-1. If statusEnable=0, hold the counter at its reload value.
  - SNAP (1 cycle): capture statusPc/statusAcc. If equal to last-shown and last-shown is valid, go to IDLE. Otherwise record them as last-shown (valid) and go to EMIT with index 0.
  - EMIT: index 0-6 presents one pending digit. Advance the index only when that digit issues. After index 6 issues, go to IDLE.
  - Clearing statusEnable during EMIT does not abort; the sequence completes.
- Field layout:
  - offset 0-3 = PC[15:12], [11:8], [7:4], [3:0].
  - offset 4 = 0x20 (space).
  - offset 5-6 = ACC[7:4], [3:0].
  - Location = (STATUS_BASE+offset) mod 32, 5-bit wrap.
- Hex encoding: nibble 0-9 -> 0x30+n; A-F -> 0x37+n (uppercase).
- Snapshot values are used for the whole sequence; input changes during EMIT wait for the next scan.
- A CPU write into the status field is allowed; it is overwritten only on the next value change.

Test Plan:
- Reset, statusEnable=1, REFRESH_DIV=4, PC=0x1A2F, ACC=0x3C, no CPU traffic -> seven consecutive strobes to locations 16-22 with data 0x31,0x41,0x32,0x46,0x20,0x33,0x43; then silence while the inputs are unchanged across further scans.
- Single cpuWrite loc=5, data=0x48 with renderer idle -> lcdWriteEnable=1 the next cycle with location=5, data=0x48; cpuReady stays 1.
- cpuWrite held 1 every cycle during EMIT with STARVE_LIMIT=8 -> 8 CPU strobes, then one renderer digit. cpuReady=0 for one cycle, and the latched CPU write issues the following cycle; the pattern repeats until all 7 digits are out.
- STATUS_BASE=29 -> digits land at locations 29,30,31,0,1,2,3.
- resetN=0 midway through EMIT (after 3 digits) -> no further strobes; outputs 0, cpuReady=1; first scan after reset re-renders all 7 digits.
- statusEnable deasserted after digit 2 -> remaining digits 3-6 still issue, then no further scans; ACC changed to 0xFF while disabled -> no strobes.
